// File: rtl/nand_alu_sequencer.sv
// Multi-cycle bitwise ALU built on one shared NAND array.
// Each op is a fixed schedule of NAND passes, one per clock.
module nand_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nand_a,
  output logic [WIDTH-1:0] nand_b,
  input  logic [WIDTH-1:0] nand_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {S_RA, S_RB, S_T, S_P, S_Q} src_t;
  typedef enum logic [1:0] {D_T, D_P, D_Q, D_R} dst_t;

  state_t state, state_nx;
  logic [2:0] step, rop;
  logic [WIDTH-1:0] ra, rb, t, p, q;
  logic [WIDTH-1:0] opa, opb;
  src_t sa, sb;
  dst_t dst;

  // Pass schedule; the pass writing R is the last one.
  always_comb begin
    sa  = S_RA;
    sb  = S_RA;
    dst = D_R;
    unique case (rop)
      3'd0: sb = S_RB;
      3'd1: begin
        if (step == 3'd0) begin
          sb  = S_RB;
          dst = D_T;
        end else begin
          sa = S_T;
          sb = S_T;
        end
      end
      3'd2, 3'd3: begin
        case (step)
          3'd0: dst = D_P;
          3'd1: begin
            sa  = S_RB;
            sb  = S_RB;
            dst = D_Q;
          end
          3'd2: begin
            sa  = S_P;
            sb  = S_Q;
            dst = (rop == 3'd3) ? D_T : D_R;
          end
          default: begin
            sa = S_T;
            sb = S_T;
          end
        endcase
      end
      3'd4, 3'd5: begin
        case (step)
          3'd0: begin
            sb  = S_RB;
            dst = D_T;
          end
          3'd1: begin
            sb  = S_T;
            dst = D_P;
          end
          3'd2: begin
            sa  = S_RB;
            sb  = S_T;
            dst = D_Q;
          end
          3'd3: begin
            sa  = S_P;
            sb  = S_Q;
            dst = (rop == 3'd5) ? D_T : D_R;
          end
          default: begin
            sa = S_T;
            sb = S_T;
          end
        endcase
      end
      3'd6: sb = S_RA;
      default: begin
        if (step == 3'd0) begin
          dst = D_T;
        end else begin
          sa = S_T;
          sb = S_T;
        end
      end
    endcase
  end

  always_comb begin
    opa = ra;
    case (sa)
      S_RB:    opa = rb;
      S_T:     opa = t;
      S_P:     opa = p;
      S_Q:     opa = q;
      default: opa = ra;
    endcase
    opb = ra;
    case (sb)
      S_RB:    opb = rb;
      S_T:     opb = t;
      S_P:     opb = p;
      S_Q:     opb = q;
      default: opb = ra;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN:     if (dst == D_R) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state == RUN) || (state == DONE);
  assign res_valid   = (state == DONE);
  assign nand_a      = (state == RUN) ? opa : '0;
  assign nand_b      = (state == RUN) ? opb : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      step   <= '0;
      rop    <= '0;
      ra     <= '0;
      rb     <= '0;
      t      <= '0;
      p      <= '0;
      q      <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_valid) begin
        rop  <= op;
        ra   <= a;
        rb   <= b;
        step <= '0;
      end
      if (state == RUN) begin
        step <= step + 3'd1;
        unique case (dst)
          D_T:     t      <= nand_result;
          D_P:     p      <= nand_result;
          D_Q:     q      <= nand_result;
          default: result <= nand_result;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_alu_sequencer.sv
// Directed bench for nand_alu_sequencer.
// Expected results come from a behavioural model via a scoreboard queue.
module tb_nand_alu_sequencer;

  localparam int W = 32;
  localparam logic [W-1:0] A = 32'hF0F0F0F0;
  localparam logic [W-1:0] B = 32'hFF00FF00;

  logic clk = 1'b0;
  logic reset_n;
  logic start_valid;
  logic start_ready;
  logic [2:0] op;
  logic [W-1:0] a, b;
  logic [W-1:0] nand_a, nand_b, nand_result;
  logic res_valid;
  logic res_ready;
  logic [W-1:0] result;
  logic busy;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  assign nand_result = ~(nand_a & nand_b);

  nand_alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op(op),
    .a(a),
    .b(b),
    .nand_a(nand_a),
    .nand_b(nand_b),
    .nand_result(nand_result),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .result(result),
    .busy(busy)
  );

  function automatic logic [W-1:0] model(input logic [2:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (o)
      3'd0:    return ~(x & y);
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  function automatic int passes(input logic [2:0] o);
    case (o)
      3'd0, 3'd6: return 1;
      3'd1, 3'd7: return 2;
      3'd2:       return 3;
      3'd3, 3'd4: return 4;
      default:    return 5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    start_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input int hold,
                        input bit scramble, input bit poke);
    int k;
    res_ready = (hold == 0);
    chk($sformatf("ready_op%0d", o), start_ready, 1);
    sb_q.push_back(model(o, A, B));
    accept(o, A, B);
    if (scramble) begin
      op = 3'd7;
      a = '0;
      b = '0;
    end
    k = 0;
    while (!res_valid && k < 20) begin
      if (poke) start_valid = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("latency_op%0d", o), k, passes(o));
    for (int i = 0; i < hold; i++) begin
      chk($sformatf("hold_valid_%0d", i), res_valid, 1);
      chk($sformatf("hold_result_%0d", i), result, sb_q[0]);
      chk($sformatf("hold_sready_%0d", i), start_ready, 0);
      @(posedge clk);
      #1;
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    chk($sformatf("result_op%0d", o), result, sb_q.pop_front());
    @(posedge clk);
    #1;
    chk($sformatf("post_valid_op%0d", o), res_valid, 0);
    chk($sformatf("post_idle_op%0d", o), start_ready, 1);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #3;
    chk("rst_sready", start_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_nand_a", nand_a, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Abort an XOR during its third pass.
    accept(3'd4, A, B);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", res_valid, 0);
    chk("abort_sready", start_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_nand_b", nand_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_idle", start_ready, 1);

    for (int o = 0; o < 8; o++) run_op(3'(o), 0, 1'b0, 1'b0);

    run_op(3'd4, 10, 1'b0, 1'b0);
    run_op(3'd1, 0, 1'b1, 1'b0);

    run_op(3'd5, 3, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (res_valid || busy) seen = 1'b1;
    end
    chk("no_second_accept", seen, 0);

    // OR datapath port sequence.
    res_ready = 1'b0;
    sb_q.push_back(model(3'd2, A, B));
    accept(3'd2, A, B);
    chk("or_p0_a", nand_a, A);
    chk("or_p0_b", nand_b, A);
    @(posedge clk);
    #1;
    chk("or_p1_a", nand_a, B);
    chk("or_p1_b", nand_b, B);
    @(posedge clk);
    #1;
    chk("or_p2_a", nand_a, ~A);
    chk("or_p2_b", nand_b, ~B);
    @(posedge clk);
    #1;
    chk("or_done_valid", res_valid, 1);
    chk("or_done_a", nand_a, 0);
    chk("or_done_b", nand_b, 0);
    chk("or_result", result, sb_q.pop_front());
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("or_post_idle", start_ready, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
